// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO: DEPTH-entry circular buffer of {pc, instr} pairs with
// flush priority. Define IF_ID_BYPASS_EN for zero-latency pass-through when empty.
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_instr,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc_add_4,
  input  logic                     id_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic empty, bypass, show, push, store, pop;

  // Output side: head entry, or NOP/zero when nothing is presentable
  always_comb begin
    empty  = (count_q == '0);
    bypass = 1'b0;
`ifdef IF_ID_BYPASS_EN
    bypass = empty && if_valid;
`endif
    if_ready = (count_q != FULL);
    show     = !empty || bypass;
    id_valid = !empty || (bypass && !flush);
    id_pc    = '0;
    id_instr = NOP;
    if (bypass) begin
      id_pc    = if_pc;
      id_instr = if_instr;
    end else if (!empty) begin
      id_pc    = pc_mem_q[rp_q];
      id_instr = instr_mem_q[rp_q];
    end
    id_pc_add_4 = show ? (id_pc + 32'd4) : '0;
  end

  // A bypassed pair consumed in the same cycle never touches storage
  always_comb begin
    push  = if_valid && if_ready && !flush;
    store = push && !(bypass && id_ready);
    pop   = !empty && id_ready && !flush;

    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (store) begin
        pc_mem_d[wp_q]    = if_pc;
        instr_mem_d[wp_q] = if_instr;
        wp_d              = wp_q + PTR_ONE;
      end
      if (pop) rp_d = rp_q + PTR_ONE;
      case ({store, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never reset; the empty-state mux hides stale contents
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign count = count_q;

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Decoupling buffer between the instruction-fetch stage and the decode stage of the RISC-V pipeline. It captures each fetched (PC, instruction) pair with a valid/ready handshake, holds up to DEPTH entries in FIFO order, and presents the oldest entry to decode along with its precomputed PC+4. A taken branch flushes every entry so that decode never sees wrong-path instructions.

## Interface

Parameters:
- DEPTH, 2, number of entries; power of two, 2..8.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately; release is synchronous to clk.
- if_valid  input  1  fetch presents a valid pair this cycle.
- if_pc  input  32  PC of the fetched instruction.
- if_instr  input  32  fetched instruction word.
- if_ready  output  1  buffer can accept a pair. High when count < DEPTH. Driven from registered state only, with no combinational path from id_ready.
- id_valid  output  1  head entry is valid for decode.
- id_pc  output  32  PC of the head entry.
- id_instr  output  32  instruction of the head entry.
- id_pc_add_4  output  32  id_pc + 4, modulo 2^32.
- id_ready  input  1  decode consumes the head this cycle when id_valid is also high.
- flush  input  1  taken branch or redirect; discards all contents.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation

- Storage is a circular array of DEPTH {pc, instr} entries with write pointer wp, read pointer rp, and counter count. Pointers wrap modulo DEPTH.
- Push: occurs when if_valid && if_ready && !flush. The pair is written at wp, then wp advances.
- Pop: occurs when id_valid && id_ready && !flush. rp advances.
- Simultaneous push and pop: count is unchanged and both pointers advance. When count == DEPTH, if_ready is low, so a pop frees a slot that becomes usable on the next cycle.
- Flush has priority over push and pop:
  - count, wp and rp go to 0 on the next edge.
  - A pair offered in the flush cycle is dropped.
  - Decode must ignore id_valid in the flush cycle.
- Empty output (count == 0, non-bypass build): id_valid=0, id_pc=0, id_instr=32'h00000013 (NOP), id_pc_add_4=0.
- Non-empty output: id_valid=1, and the outputs reflect the entry at rp.
- When id_valid is high and id_ready is low, the outputs hold stable.
- Reset values (rst low): count=0, wp=rp=0, if_ready=1, id_valid=0, id_pc=0, id_instr=32'h00000013, id_pc_add_4=0.
- Reset asserted mid-operation discards all entries immediately and asynchronously.

## Timing

- Latency: a pair pushed at edge N is visible at the outputs after edge N, i.e. available to decode in cycle N+1. The bypass build changes this (see Configuration).
- Throughput: one push and one pop per cycle.
- if_ready deasserts in the cycle after the push that fills the buffer.
- Wrap-around: the pointers roll from DEPTH-1 to 0 without any bubble.
- flush takes effect at the next edge. In the cycle after flush, id_valid=0 and if_ready=1.

## Configuration

- IF_ID_BYPASS_EN defined:
  - When count == 0 and if_valid is high, the outputs show if_pc/if_instr combinationally, with id_valid = if_valid && !flush.
  - If id_ready is also high, the pair is consumed in the same cycle and is not written to storage.
  - Result: zero-cycle latency on an empty buffer.
- IF_ID_BYPASS_EN undefined: the one-cycle latency described under Timing, and no combinational path from the if_* inputs to the id_* outputs.

## Test plan

- Reset: hold rst low mid-stream with count=2 -> outputs immediately become id_valid=0, id_instr=32'h00000013, count=0, if_ready=1.
- Single pair: push pc=0x100, instr=0x00500093 with id_ready=1 -> next cycle id_valid=1, id_pc=0x100, id_pc_add_4=0x104. One cycle later id_valid=0.
- Fill/backpressure: id_ready=0, push 3 pairs with DEPTH=2 -> if_ready low after the 2nd push, the 3rd pair is not accepted, count=2. Then raise id_ready -> pairs emerge in order 0x100, 0x104.
- Wrap: stream 10 consecutive pairs with id_ready=1 -> decode sees all 10 in order with no gaps; pointers wrap with no bubble.
- Flush: count=2 and flush=1 together with if_valid=1 (pc=0x200) -> next cycle count=0 and id_valid=0; 0x200 is never seen by decode.
- Bypass (IF_ID_BYPASS_EN): empty buffer, if_valid=1, pc=0x300, id_ready=1 -> in the same cycle id_valid=1 and id_pc=0x300; count stays 0.
